mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port o_imem_req, output, 1 bit: instruction fetch request.
REQ-004 SHALL have port i_imem_valid, input, 1 bit: fetch data valid; completes the fetch handshake.
REQ-005 SHALL have port i_imem_rdata, input, 32 bits: fetched instruction.
REQ-006 SHALL have port o_dmem_req, output, 1 bit: data memory request.
REQ-007 SHALL have port o_dmem_wen, output, 1 bit: 1=store, 0=load; qualified by o_dmem_req.
REQ-008 SHALL have port i_dmem_valid, input, 1 bit: data access complete.
REQ-009 SHALL have port i_branch_taken, input, 1 bit: ALU branch-condition result.
REQ-010 SHALL have port o_inst, output, 32 bits: instruction register, feeds the immediate generator's i_inst.
REQ-011 SHALL have port o_format, output, 6 bits: one-hot format to the immediate generator; bit0=R, bit1=I, bit2=S, bit3=B, bit4=U, bit5=J.
REQ-012 SHALL have port o_pc_wen, output, 1 bit: PC update strobe.
REQ-013 SHALL have port o_pc_sel, output, 2 bits: 0=PC+4, 1=PC+imm, 2=rs1+imm (JALR).
REQ-014 SHALL have port o_rf_wen, output, 1 bit: register-file write strobe.
REQ-015 SHALL have port o_wb_sel, output, 2 bits: 0=ALU, 1=load data, 2=PC+4.
REQ-016 SHALL have port o_halt, output, 1 bit: core halted.
REQ-017 SHALL have port o_illegal, output, 1 bit: halted on illegal opcode.

Function
REQ-018 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 FETCH: o_imem_req=1 until i_imem_valid=1; on that cycle, latch i_imem_rdata into o_inst and go to DECODE. The wait is unbounded.
REQ-020 DECODE SHALL last exactly 1 cycle and then go to EXEC.
REQ-021 o_format SHALL be decoded combinationally from o_inst[6:0] in DECODE/EXEC/MEM/WB, and SHALL be 0 in FETCH and HALT.
REQ-022 Opcode-to-format mapping:
- 0110011 -> R.
- 0010011, 0000011, 1100111 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
REQ-023 EXEC for BRANCH: o_pc_wen=1, o_pc_sel=1 if i_branch_taken else 0; next state FETCH.
REQ-024 EXEC for LOAD/STORE: next state MEM. EXEC for all other legal opcodes: next state WB.
REQ-025 MEM: o_dmem_req=1, o_dmem_wen=(opcode==STORE), held until i_dmem_valid=1. On that cycle, a STORE asserts o_pc_wen (sel 0) and goes to FETCH; a LOAD goes to WB.
REQ-026 WB SHALL last 1 cycle with o_rf_wen=1 and o_pc_wen=1, then go to FETCH.
- o_wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
- o_pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
REQ-027 SYSTEM opcode 1110011 with o_inst==0x00100073 (EBREAK) SHALL go from EXEC to HALT with no PC or RF write.
REQ-028 HALT SHALL assert o_halt=1 and SHALL be left only by reset; all request and strobe outputs are 0 in HALT.
REQ-029 Strobes (o_pc_wen, o_rf_wen, o_imem_req, o_dmem_req) SHALL be 0 in every state/cycle not listed above.
REQ-030 Exactly one o_pc_wen pulse SHALL occur per retired instruction.
REQ-031 Latency with 1-cycle memory response: ALU/U/J ops 4 cycles; LOAD 5; STORE 4; BRANCH 3.

Reset
REQ-032 While i_rst_n=0 at a rising edge, next state SHALL be FETCH; o_inst=0x00000013; o_halt=0; o_illegal=0.
REQ-033 All request and strobe outputs SHALL be 0 while i_rst_n=0.
REQ-034 Reset asserted mid-instruction (any state, including during a MEM wait) SHALL abort the instruction with no PC/RF write; the first fetch request comes in the cycle after release.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN defined: an unlisted opcode, or a SYSTEM instruction other than EBREAK, SHALL go EXEC->HALT with o_illegal=1 and o_halt=1.
REQ-036 ILLEGAL_TRAP_EN undefined: such instructions SHALL retire as NOPs (EXEC: o_pc_wen=1, sel 0, no RF write, -> FETCH), and o_illegal SHALL be tied 0.

Verification
REQ-037 Reset, then ADDI 0x07B10093 with i_imem_valid immediate -> DECODE o_format=000010; WB cycle o_rf_wen=1, o_wb_sel=0, o_pc_sel=0; total 4 cycles.
REQ-038 BEQ 0x00208463: i_branch_taken=1 -> o_format=001000, EXEC o_pc_wen=1, o_pc_sel=1; repeat with taken=0 -> o_pc_sel=0; no o_rf_wen in either case.
REQ-039 LW with i_dmem_valid delayed 3 cycles -> o_dmem_req=1, o_dmem_wen=0 for 4 cycles, then WB with o_wb_sel=1; SW 0x06312223 -> o_format=000100, o_dmem_wen=1, no o_rf_wen.
REQ-040 JAL 0x014000EF -> o_format=100000; WB o_rf_wen=1, o_wb_sel=2, o_pc_sel=1; JALR -> o_pc_sel=2.
REQ-041 EBREAK 0x00100073 -> o_halt=1 held 20 cycles, no o_imem_req; then i_rst_n=0 for one edge -> o_halt=0, FETCH resumes.
REQ-042 Opcode 0x0000007F: with ILLEGAL_TRAP_EN -> o_illegal=1, o_halt=1; without -> single o_pc_wen (sel 0), next fetch; reset during a MEM wait -> no o_pc_wen/o_rf_wen.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle core control FSM; ILLEGAL_TRAP_EN enables the illegal-opcode halt trap
module mc_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  input  logic        i_dmem_valid,
  input  logic        i_branch_taken,
  output logic [31:0] o_inst,
  output logic [5:0]  o_format,
  output logic        o_pc_wen,
  output logic [1:0]  o_pc_sel,
  output logic        o_rf_wen,
  output logic [1:0]  o_wb_sel,
  output logic        o_halt,
  output logic        o_illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  state_t     state, state_nxt;
  logic [6:0] opcode;
  logic [5:0] fmt_dec;
  logic       is_legal;
  logic       is_ebreak;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;

  assign opcode    = o_inst[6:0];
  assign is_ebreak = (o_inst == INST_EBREAK);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  // SYSTEM is legal only as EBREAK; every other SYSTEM encoding is treated as unlisted
  always_comb begin
    fmt_dec  = 6'b000000;
    is_legal = 1'b1;
    case (opcode)
      OP_R:                      fmt_dec = 6'b000001;
      OP_IMM, OP_LOAD, OP_JALR:  fmt_dec = 6'b000010;
      OP_STORE:                  fmt_dec = 6'b000100;
      OP_BRANCH:                 fmt_dec = 6'b001000;
      OP_LUI, OP_AUIPC:          fmt_dec = 6'b010000;
      OP_JAL:                    fmt_dec = 6'b100000;
      OP_SYSTEM:                 is_legal = is_ebreak;
      default:                   is_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_inst <= INST_NOP;
    end else if (state == S_FETCH && i_imem_valid) begin
      o_inst <= i_imem_rdata;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_illegal <= 1'b0;
    end else if (state == S_EXEC && !is_legal) begin
      o_illegal <= 1'b1;
    end
  end
`else
  assign o_illegal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (i_imem_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_ebreak) begin
          state_nxt = S_HALT;
        end else if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_FETCH;
`endif
        end else if (is_branch) begin
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM:    if (i_dmem_valid) state_nxt = is_store ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Strobes are gated by the raw reset input so nothing escapes during a reset cycle
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_wen = 1'b0;
    o_pc_wen   = 1'b0;
    o_pc_sel   = 2'd0;
    o_rf_wen   = 1'b0;
    o_wb_sel   = 2'd0;
    if (i_rst_n) begin
      case (state)
        S_FETCH: o_imem_req = 1'b1;
        S_EXEC: begin
          if (is_branch) begin
            o_pc_wen = 1'b1;
            o_pc_sel = {1'b0, i_branch_taken};
          end
`ifndef ILLEGAL_TRAP_EN
          else if (!is_legal) begin
            o_pc_wen = 1'b1;
          end
`endif
        end
        S_MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_wen = is_store;
          o_pc_wen   = i_dmem_valid && is_store;
        end
        S_WB: begin
          o_rf_wen = 1'b1;
          o_pc_wen = 1'b1;
          o_wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
          o_pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_format = 6'b000000;
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      o_format = fmt_dec;
    end
  end

  assign o_halt = (state == S_HALT);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized scoreboard bench for mc_ctrl
module tb_mc_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_dmem_req;
  logic        o_dmem_wen;
  logic        i_dmem_valid;
  logic        i_branch_taken;
  logic [31:0] o_inst;
  logic [5:0]  o_format;
  logic        o_pc_wen;
  logic [1:0]  o_pc_sel;
  logic        o_rf_wen;
  logic [1:0]  o_wb_sel;
  logic        o_halt;
  logic        o_illegal;

  mc_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .i_dmem_valid(i_dmem_valid),
    .i_branch_taken(i_branch_taken), .o_inst(o_inst), .o_format(o_format),
    .o_pc_wen(o_pc_wen), .o_pc_sel(o_pc_sel), .o_rf_wen(o_rf_wen), .o_wb_sel(o_wb_sel),
    .o_halt(o_halt), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef ILLEGAL_TRAP_EN
  localparam int NOPS = 9;
`else
  localparam int NOPS = 11;
`endif

  typedef struct {
    int fmt;
    int pc_sel;
    int rf;
    int wb_sel;
    int lat;
    int store;
  } exp_t;

  exp_t        expq[$];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          acc_cyc = -10;
  int          exp_fmt = 0;
  int          issued = 0;
  bit          hold = 1'b1;
  int          iwait = 0;
  int          dwait = 0;
  logic [31:0] nxt_inst = 32'h13;
  bit          nxt_taken = 1'b0;
  int          nxt_d = 0;
  bit          nxt_push = 1'b1;
  logic [6:0]  ops [0:9];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: format by opcode class, which strobes retire it, and how many
  // cycles from fetch acceptance to the retiring PC write (d = extra memory wait cycles)
  function automatic exp_t model(input logic [31:0] inst, input bit taken, input int d);
    exp_t e;
    e = '{fmt: 0, pc_sel: 0, rf: 1, wb_sel: 0, lat: 4, store: 0};
    case (inst[6:0])
      7'h33:        e.fmt = 1;
      7'h13:        e.fmt = 2;
      7'h03:        begin e.fmt = 2; e.wb_sel = 1; e.lat = 5 + d; end
      7'h67:        begin e.fmt = 2; e.wb_sel = 2; e.pc_sel = 2; end
      7'h23:        begin e.fmt = 4; e.rf = 0; e.lat = 4 + d; e.store = 1; end
      7'h63:        begin e.fmt = 8; e.rf = 0; e.lat = 3; e.pc_sel = taken ? 1 : 0; end
      7'h37, 7'h17: e.fmt = 16;
      7'h6f:        begin e.fmt = 32; e.wb_sel = 2; e.pc_sel = 1; end
      default:      begin e.rf = 0; e.lat = 3; end
    endcase
    return e;
  endfunction

  task automatic plan_random();
    int k;
    k = $urandom_range(0, NOPS - 1);
    nxt_inst = $urandom();
    if (k == 10) begin
      nxt_inst[6:0] = 7'h73;
      if (nxt_inst == EBREAK) nxt_inst[31] = 1'b1;
    end else begin
      nxt_inst[6:0] = ops[k];
    end
    nxt_taken = 1'($urandom_range(0, 1));
    nxt_d     = $urandom_range(0, 3);
    nxt_push  = 1'b1;
  endtask

  // One clock of memory-side driving, applied just after the active edge
  task automatic step();
    exp_t e;
    @(posedge i_clk);
    #1;
    i_imem_valid = 1'b0;
    i_dmem_valid = 1'b0;
    if (o_imem_req && !hold) begin
      if (iwait == 0) begin
        i_imem_valid   = 1'b1;
        i_imem_rdata   = nxt_inst;
        i_branch_taken = nxt_taken;
        e = model(nxt_inst, nxt_taken, nxt_d);
        exp_fmt = e.fmt;
        if (nxt_push) expq.push_back(e);
        dwait = nxt_d;
        issued++;
        plan_random();
        iwait = $urandom_range(0, 2);
      end else begin
        iwait--;
      end
    end
    if (o_dmem_req) begin
      if (dwait == 0) i_dmem_valid = 1'b1;
      else dwait--;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && expq.size() != 0; i++) step();
    if (expq.size() != 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic run_one(input logic [31:0] inst, input bit taken, input int d, input bit push);
    int start;
    nxt_inst = inst; nxt_taken = taken; nxt_d = d; nxt_push = push;
    iwait = 0; hold = 1'b0; start = issued;
    for (int i = 0; i < 50 && issued == start; i++) step();
    hold = 1'b1;
    if (issued == start) chk("issue_timeout", 0, 1);
    if (push) drain();
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 10 && !o_halt; i++) step();
    chk("halt_reached", int'(o_halt), 1);
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    step();
    expq.delete();
    dwait = 0;
    chk("reset_halt", int'(o_halt), 0);
    chk("reset_illegal", int'(o_illegal), 0);
    chk("reset_inst", int'(o_inst), 32'h13);
    i_rst_n = 1'b1;
    #1;
    chk("fetch_after_reset", int'(o_imem_req), 1);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge i_clk);
      cyc++;
      if (!i_rst_n) begin
        chk("reset_strobes", int'({o_imem_req, o_dmem_req, o_pc_wen, o_rf_wen}), 0);
      end else begin
        if (o_imem_req && i_imem_valid) begin
          acc_cyc = cyc;
          chk("fetch_format", int'(o_format), 0);
        end
        if (cyc == acc_cyc + 1) chk("decode_format", int'(o_format), exp_fmt);
        if (o_dmem_req && expq.size() > 0) chk("dmem_wen", int'(o_dmem_wen), expq[0].store);
        if (o_pc_wen) begin
          if (expq.size() == 0) begin
            chk("unexpected_pc_wen", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("pc_sel", int'(o_pc_sel), e.pc_sel);
            chk("rf_wen", int'(o_rf_wen), e.rf);
            if (e.rf != 0) chk("wb_sel", int'(o_wb_sel), e.wb_sel);
            chk("latency", cyc - acc_cyc + 1, e.lat);
          end
        end else if (o_rf_wen) begin
          chk("rf_wen_without_pc_wen", 1, 0);
        end
      end
    end
  end

  initial begin
    int start;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h67; ops[4] = 7'h23;
    ops[5] = 7'h63; ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6f; ops[9] = 7'h7f;
    i_rst_n = 1'b0; i_imem_valid = 1'b0; i_imem_rdata = 32'h0;
    i_dmem_valid = 1'b0; i_branch_taken = 1'b0;
    repeat (3) step();
    chk("reset_inst", int'(o_inst), 32'h13);
    chk("reset_halt", int'(o_halt), 0);
    chk("reset_illegal", int'(o_illegal), 0);
    i_rst_n = 1'b1;
    #1;
    chk("fetch_after_reset", int'(o_imem_req), 1);

    run_one(32'h07B1_0093, 1'b0, 0, 1'b1);
    run_one(32'h0020_8463, 1'b1, 0, 1'b1);
    run_one(32'h0020_8463, 1'b0, 0, 1'b1);
    run_one(32'h0041_2083, 1'b0, 3, 1'b1);
    run_one(32'h0631_2223, 1'b0, 0, 1'b1);
    run_one(32'h0140_00EF, 1'b0, 0, 1'b1);
    run_one(32'h0000_80E7, 1'b0, 0, 1'b1);

    plan_random();
    hold = 1'b0;
    start = issued;
    for (int i = 0; i < 6000 && issued < start + 200; i++) step();
    hold = 1'b1;
    if (issued < start + 200) chk("random_issue_timeout", issued - start, 200);
    drain();

    // Reset while a load waits on data memory must abort it without any write
    nxt_inst = 32'h0041_2083; nxt_taken = 1'b0; nxt_d = 12; nxt_push = 1'b1;
    iwait = 0; hold = 1'b0;
    for (int i = 0; i < 20 && !o_dmem_req; i++) step();
    hold = 1'b1;
    chk("mem_wait_reached", int'(o_dmem_req), 1);
    step();
    step();
    pulse_reset();
    run_one(32'h0000_0033, 1'b0, 0, 1'b1);

    run_one(EBREAK, 1'b0, 0, 1'b0);
    wait_halt();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_held", int'(o_halt), 1);
      chk("halt_no_fetch", int'(o_imem_req), 0);
      chk("halt_format", int'(o_format), 0);
    end
    pulse_reset();
    run_one(32'h0000_0013, 1'b0, 0, 1'b1);

`ifdef ILLEGAL_TRAP_EN
    run_one(32'h0000_007F, 1'b0, 0, 1'b0);
    wait_halt();
    chk("illegal_flag", int'(o_illegal), 1);
    pulse_reset();
`else
    run_one(32'h0000_007F, 1'b0, 0, 1'b1);
    chk("illegal_tied_low", int'(o_illegal), 0);
`endif
    run_one(32'h0000_0037, 1'b0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
